// File: rtl/ifu_rand_pkg.sv
// Shared types and defaults for the IFU random-number source.
// Holds the default LFSR geometry, reset seed and draw-FSM state encoding.
package ifu_rand_pkg;

  localparam int DEF_LFSR_W = 168;
  localparam int DEF_OUT_W  = 3;
  localparam int DEF_TAP_A  = 167;
  localparam int DEF_TAP_B  = 135;
  localparam int DEF_TAP_C  = 103;
  localparam int DEF_TAP_D  = 71;

  // Reset and lock-up recovery state; must never be all-ones.
  localparam logic [DEF_LFSR_W-1:0] DEF_SEED =
    168'he307465a1c9f2d8b3e6071a4c2d95f3b8e1d060b83;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } rand_state_e;

endpackage

// File: rtl/ifu_lfsr_core.sv
// XNOR LFSR advancing OUT_W bits per enabled step, with seed load/sanitise and
// all-ones lock-up recovery. raw_o is the next OUT_W feedback bits of the current state.
module ifu_lfsr_core
  import ifu_rand_pkg::*;
#(
  parameter int                LFSR_W = DEF_LFSR_W,
  parameter int                OUT_W  = DEF_OUT_W,
  parameter int                TAP_A  = DEF_TAP_A,
  parameter int                TAP_B  = DEF_TAP_B,
  parameter int                TAP_C  = DEF_TAP_C,
  parameter int                TAP_D  = DEF_TAP_D,
  parameter logic [LFSR_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en_i,
  input  logic              seed_we_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [OUT_W-1:0]  raw_o,
  output logic              lockup_o
);

  if (TAP_D < OUT_W - 1) begin : g_bad_tap_d
    $error("ifu_lfsr_core: TAP_D must be >= OUT_W-1");
  end
  if (TAP_A >= LFSR_W) begin : g_bad_tap_a
    $error("ifu_lfsr_core: TAP_A must be < LFSR_W");
  end
  if (OUT_W >= LFSR_W) begin : g_bad_out_w
    $error("ifu_lfsr_core: OUT_W must be < LFSR_W");
  end
  if (&SEED) begin : g_bad_seed
    $error("ifu_lfsr_core: SEED must not be all-ones");
  end

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] seed_ok;
  logic              all_ones;
  logic              lfsr_we;

  // Single read point for the current state; all feedback and recovery logic uses it.
  assign lfsr = lfsr_q;

  for (genvar k = 0; k < OUT_W; k++) begin : g_raw
    localparam int J = OUT_W - 1 - k;
    assign raw_o[k] = ~(lfsr[TAP_A-J] ^ lfsr[TAP_B-J] ^ lfsr[TAP_C-J] ^ lfsr[TAP_D-J]);
  end

  // An all-ones seed would lock an XNOR LFSR, so it is replaced by the default seed.
  assign seed_ok  = (&seed_i) ? SEED : seed_i;
  assign all_ones = &lfsr;
  assign lfsr_we  = seed_we_i | all_ones | en_i;

  always_comb begin
    lfsr_d = lfsr;
    if (seed_we_i)     lfsr_d = seed_ok;
    else if (all_ones) lfsr_d = SEED;
    else if (en_i)     lfsr_d = {lfsr[LFSR_W-OUT_W-1:0], raw_o};
  end

  rvdffs #(.WIDTH(LFSR_W), .RST_VAL(SEED)) u_lfsr_ff (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (lfsr_we),
    .din   (lfsr_d),
    .dout  (lfsr_q)
  );

  // Sticky until the next seed write; a seed write in the lock-up cycle wins and clears it.
  rvdffs #(.WIDTH(1), .RST_VAL(1'b0)) u_lockup_ff (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (seed_we_i | all_ones),
    .din   (~seed_we_i),
    .dout  (lockup_o)
  );

endmodule

// File: rtl/rvdff.sv
// Plain D flop vector with asynchronous active-low reset to a fixed value.
module rvdff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // NOTE: non-blocking so every flop samples pre-edge values, whatever the order of evaluation.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= RST_VAL;
    else        dout <= din;
  end

endmodule

// File: rtl/rvdffs.sv
// D flop vector with load enable and asynchronous active-low reset to a fixed value.
module rvdffs #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)  dout <= RST_VAL;
    else if (en) dout <= din;
  end

endmodule

// File: rtl/ifu_rand_gen.sv
// IFU random-number source: LFSR core plus a req/valid draw port returning
// uniform values in [0,RANGE_MAX] by rejection sampling with a bounded-retry fold fallback.
module ifu_rand_gen
  import ifu_rand_pkg::*;
#(
  parameter int                LFSR_W    = DEF_LFSR_W,
  parameter int                OUT_W     = DEF_OUT_W,
  parameter int                TAP_A     = DEF_TAP_A,
  parameter int                TAP_B     = DEF_TAP_B,
  parameter int                TAP_C     = DEF_TAP_C,
  parameter int                TAP_D     = DEF_TAP_D,
  parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
  parameter int                RANGE_MAX = 2**OUT_W - 1,
  parameter int                MAX_RETRY = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en_i,
  input  logic              seed_we_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              req_i,
  output logic              busy_o,
  output logic              rnd_valid_o,
  output logic [OUT_W-1:0]  rnd_o,
  output logic [OUT_W-1:0]  raw_o,
  output logic              lockup_o
);

  if (RANGE_MAX < 2**(OUT_W-1) - 1 || RANGE_MAX > 2**OUT_W - 1) begin : g_bad_range
    $error("ifu_rand_gen: RANGE_MAX must lie in 2**(OUT_W-1)-1 .. 2**OUT_W-1");
  end
  if (MAX_RETRY < 0) begin : g_bad_retry
    $error("ifu_rand_gen: MAX_RETRY must be >= 0");
  end

  localparam int                 RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [OUT_W:0]     RANGE_X   = (OUT_W+1)'(RANGE_MAX);
  localparam logic [OUT_W-1:0]   FOLD_SUB  = OUT_W'(RANGE_MAX + 1);

  logic [OUT_W-1:0]   raw;
  logic [OUT_W:0]     cand_x;
  rand_state_e        state_q;
  rand_state_e        state_d;
  logic               state_bit;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;
  logic [OUT_W-1:0]   rnd_d;
  logic               valid_d;

  ifu_lfsr_core #(
    .LFSR_W (LFSR_W),
    .OUT_W  (OUT_W),
    .TAP_A  (TAP_A),
    .TAP_B  (TAP_B),
    .TAP_C  (TAP_C),
    .TAP_D  (TAP_D),
    .SEED   (SEED)
  ) u_core (
    .clk       (clk),
    .rst_l     (rst_l),
    .en_i      (en_i),
    .seed_we_i (seed_we_i),
    .seed_i    (seed_i),
    .raw_o     (raw),
    .lockup_o  (lockup_o)
  );

  assign raw_o   = raw;
  assign state_q = rand_state_e'(state_bit);
  assign busy_o  = (state_q == DRAW);
  // Compare one bit wider so a full-range RANGE_MAX is not a constant comparison.
  assign cand_x  = {1'b0, raw};

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    rnd_d   = raw;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = DRAW;
          retry_d = '0;
        end
      end
      DRAW: begin
        if (en_i) begin
          if (cand_x <= RANGE_X) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
          end else begin
            rnd_d   = raw - FOLD_SUB;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  rvdff #(.WIDTH(1), .RST_VAL(1'b0)) u_state_ff (
    .clk   (clk),
    .rst_l (rst_l),
    .din   (state_d),
    .dout  (state_bit)
  );

  rvdff #(.WIDTH(RETRY_W), .RST_VAL('0)) u_retry_ff (
    .clk   (clk),
    .rst_l (rst_l),
    .din   (retry_d),
    .dout  (retry_q)
  );

  rvdff #(.WIDTH(1), .RST_VAL(1'b0)) u_valid_ff (
    .clk   (clk),
    .rst_l (rst_l),
    .din   (valid_d),
    .dout  (rnd_valid_o)
  );

  rvdffs #(.WIDTH(OUT_W), .RST_VAL('0)) u_rnd_ff (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (valid_d),
    .din   (rnd_d),
    .dout  (rnd_o)
  );

endmodule

// File: tb/tb_ifu_rand_gen.sv
// Scoreboard bench for ifu_rand_gen: two instances (RANGE_MAX=7 and RANGE_MAX=5) share
// en/seed stimulus; expected draws are queued at request time and popped on rnd_valid_o.
module tb_ifu_rand_gen;
  import ifu_rand_pkg::*;

  localparam int W = DEF_LFSR_W;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic         en = 1'b0;
  logic         seed_we = 1'b0;
  logic [W-1:0] seed = '0;
  logic         req7 = 1'b0;
  logic         req5 = 1'b0;
  logic         force_ones = 1'b0;

  logic       busy7, v7, lock7, busy5, v5, lock5;
  logic [2:0] rnd7, raw7, rnd5, raw5;

  ifu_rand_gen u_dut7 (
    .clk (clk), .rst_l (rst_l), .en_i (en), .seed_we_i (seed_we), .seed_i (seed),
    .req_i (req7), .busy_o (busy7), .rnd_valid_o (v7), .rnd_o (rnd7), .raw_o (raw7),
    .lockup_o (lock7)
  );

  ifu_rand_gen #(.RANGE_MAX(5), .MAX_RETRY(4)) u_dut5 (
    .clk (clk), .rst_l (rst_l), .en_i (en), .seed_we_i (seed_we), .seed_i (seed),
    .req_i (req5), .busy_o (busy5), .rnd_valid_o (v5), .rnd_o (rnd5), .raw_o (raw5),
    .lockup_o (lock5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference XNOR LFSR for the default geometry (taps 167/135/103/71, 3 bits per step).
  function automatic logic [2:0] raw_of(input logic [W-1:0] s);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) begin
      r[k] = ~(s[167-(2-k)] ^ s[135-(2-k)] ^ s[103-(2-k)] ^ s[71-(2-k)]);
    end
    return r;
  endfunction

  logic [W-1:0] m_lfsr;
  logic [W-1:0] m_cur;
  assign m_cur = force_ones ? '1 : m_lfsr;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l)           m_lfsr <= DEF_SEED;
    else if (seed_we)     m_lfsr <= (&seed) ? DEF_SEED : seed;
    else if (&m_cur)      m_lfsr <= DEF_SEED;
    else if (en)          m_lfsr <= {m_cur[W-4:0], raw_of(m_cur)};
  end

  typedef struct {
    logic [2:0] val;
    int         cyc;
  } exp_t;

  exp_t q7[$];
  exp_t q5[$];
  exp_t e7, e5;

  always @(negedge clk) begin
    if (v7) begin
      if (q7.size() == 0) check("d7_spurious_pulse", 1'b1, 1'b0);
      else begin
        e7 = q7.pop_front();
        check("d7_rnd", rnd7, e7.val);
        check("d7_pulse_cycle", cyc, e7.cyc);
      end
    end
    if (v5) begin
      if (q5.size() == 0) check("d5_spurious_pulse", 1'b1, 1'b0);
      else begin
        e5 = q5.pop_front();
        check("d5_rnd", rnd5, e5.val);
        check("d5_pulse_cycle", cyc, e5.cyc);
      end
    end
  end

  task automatic reseed_zero();
    seed = '0;
    seed_we = 1'b1;
    tick();
    seed_we = 1'b0;
  endtask

  initial begin
    int t;

    // Reset state while rst_l is held low.
    #12;
    check("rst_busy", busy7, 1'b0);
    check("rst_valid", v7, 1'b0);
    check("rst_rnd", rnd7, 3'd0);
    check("rst_lockup", lock7, 1'b0);
    check("rst_lfsr", u_dut7.u_core.lfsr, DEF_SEED);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    check("seed_raw", raw7, raw_of(DEF_SEED));

    // Free-running stream against the reference model.
    en = 1'b1;
    repeat (1000) begin
      tick();
      check("raw_stream", raw7, raw_of(m_lfsr));
    end
    check("lfsr_stream", u_dut7.u_core.lfsr, m_lfsr);

    // Zero seed: raw stays 3'b111 for many steps. RANGE_MAX=7 accepts at T+2;
    // RANGE_MAX=5 rejects four times and folds 7-6=1 at T+6.
    reseed_zero();
    t = cyc;
    req7 = 1'b1;
    req5 = 1'b1;
    q7.push_back('{val: 3'd7, cyc: t + 2});
    q5.push_back('{val: 3'd1, cyc: t + 6});
    tick();
    req7 = 1'b0;
    req5 = 1'b0;
    check("draw_busy_t1", busy7, 1'b1);
    tick();
    check("accept_busy_t2", busy7, 1'b0);
    check("retry_busy_t2", busy5, 1'b1);
    tick(4);
    check("fold_busy_t6", busy5, 1'b0);
    tick(2);

    // en_i low for three cycles mid-DRAW; a request while busy is dropped.
    reseed_zero();
    t = cyc;
    req7 = 1'b1;
    req5 = 1'b1;
    q7.push_back('{val: 3'd7, cyc: t + 2});
    q5.push_back('{val: 3'd1, cyc: t + 9});
    tick();
    req7 = 1'b0;
    req5 = 1'b0;
    tick();
    en = 1'b0;
    req5 = 1'b1;
    tick();
    req5 = 1'b0;
    tick(2);
    check("stall_retry_frozen", u_dut5.retry_q, 3'd1);
    check("stall_lfsr_frozen", u_dut7.u_core.lfsr, m_lfsr);
    check("stall_busy", busy5, 1'b1);
    en = 1'b1;
    tick(6);

    // All-ones seed is sanitised to the default seed without flagging lock-up.
    seed = '1;
    seed_we = 1'b1;
    tick();
    seed_we = 1'b0;
    check("ones_seed_lfsr", u_dut7.u_core.lfsr, DEF_SEED);
    check("ones_seed_lockup", lock7, 1'b0);

    // Forced lock-up state recovers to the default seed and sets the sticky flag.
    force_ones = 1'b1;
    force u_dut7.u_core.lfsr = '1;
    #1;
    check("lockup_raw", raw7, 3'b111);
    tick();
    release u_dut7.u_core.lfsr;
    force_ones = 1'b0;
    #1;
    check("lockup_lfsr", u_dut7.u_core.lfsr, DEF_SEED);
    check("lockup_flag", lock7, 1'b1);

    // Seed write in the same edge as lock-up wins and clears the flag.
    seed = '0;
    seed_we = 1'b1;
    force_ones = 1'b1;
    force u_dut7.u_core.lfsr = '1;
    tick();
    release u_dut7.u_core.lfsr;
    force_ones = 1'b0;
    seed_we = 1'b0;
    #1;
    check("seedwin_lfsr", u_dut7.u_core.lfsr, {W{1'b0}});
    check("seedwin_lockup", lock7, 1'b0);
    check("seedwin_model", raw7, raw_of(m_lfsr));

    // Reset mid-DRAW: FSM idles, rnd_o clears, no pulse follows.
    reseed_zero();
    req5 = 1'b1;
    tick();
    req5 = 1'b0;
    tick();
    check("pre_rst_busy", busy5, 1'b1);
    rst_l = 1'b0;
    #1;
    check("mid_rst_busy", busy5, 1'b0);
    check("mid_rst_rnd", rnd5, 3'd0);
    check("mid_rst_valid", v5, 1'b0);
    tick(2);
    rst_l = 1'b1;
    tick(8);
    check("post_rst_busy", busy5, 1'b0);
    check("post_rst_raw", raw7, raw_of(m_lfsr));

    check("q7_drained", q7.size(), 0);
    check("q5_drained", q5.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
